// File: rtl/video_timing_pkg.sv
// video_timing_pkg: lock FSM encoding and raster size helpers shared by the video timing stage
package video_timing_pkg;
  typedef enum logic [1:0] {SEEK, WAIT, LOCKED} state_t;
  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int cnt_w(input int tot);
    return (tot > 2) ? $clog2(tot) : 1;
  endfunction
endpackage

// File: rtl/video_timing_counter.sv
// video_timing_counter: free-running h/v raster counters with active/hsync/vsync/origin/eol decode; i_clk, i_rst_n (async low) in, decodes out
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_active,
  output logic o_hs,
  output logic o_vs,
  output logic o_origin,
  output logic o_eol
);
  localparam int HT = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = cnt_w(HT);
  localparam int VW = cnt_w(VT);
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [31:0] w_h, w_v;
  assign w_h = 32'(r_hcnt);
  assign w_v = 32'(r_vcnt);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_hcnt <= (w_h == HT - 1) ? '0 : r_hcnt + HW'(1);
      if (w_h == HT - 1) r_vcnt <= (w_v == VT - 1) ? '0 : r_vcnt + VW'(1);
    end
  assign o_active = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
  assign o_hs     = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
  assign o_vs     = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);
  assign o_origin = (r_hcnt == '0) && (r_vcnt == '0);
  assign o_eol    = (w_h == H_ACTIVE - 1);
endmodule

// File: rtl/axis_video_timing.sv
// axis_video_timing: AXI4-Stream RGB to registered video timing (rgb/hsync/vsync/de) with a raster lock FSM; ports: axis_aclk, axis_aresetn (async low), s_axis_* stream in, video + locked/underflow/sync_err out
module axis_video_timing
  import video_timing_pkg::*;
#(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter logic [23:0] BLANK_RGB = 24'h000000
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        locked,
  output logic        underflow,
  output logic        sync_err
);
  state_t r_state;
  logic [23:0] r_rgb;
  logic r_de, r_hsync, r_vsync, r_locked, r_underflow, r_sync_err;
  logic w_active, w_hs, w_vs, w_origin, w_eol, w_sof, w_slot, w_err, w_unused;
  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .i_clk(axis_aclk), .i_rst_n(axis_aresetn), .o_active(w_active),
    .o_hs(w_hs), .o_vs(w_vs), .o_origin(w_origin), .o_eol(w_eol)
  );
  assign w_sof = s_axis_tvalid & s_axis_tuser;
  // the held SOF beat is consumed in the (0,0) slot as the first locked pixel
  assign w_slot = w_active & ((r_state == LOCKED) | ((r_state == WAIT) & w_origin));
  assign w_err = (s_axis_tuser != w_origin) | (s_axis_tlast != w_eol);
  assign s_axis_tready = axis_aresetn & ((r_state == SEEK) ? ~w_sof : w_slot);
  assign w_unused = ^s_axis_tdata[31:24];
  assign {red, green, blue} = r_rgb;
  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign de = r_de;
  assign locked = r_locked;
  assign underflow = r_underflow;
  assign sync_err = r_sync_err;
  always_ff @(posedge axis_aclk or negedge axis_aresetn)
    if (!axis_aresetn) begin
      r_state     <= SEEK;
      r_rgb       <= '0;
      r_de        <= 1'b0;
      r_hsync     <= ~HS_POL;
      r_vsync     <= ~VS_POL;
      r_locked    <= 1'b0;
      r_underflow <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_de        <= w_active;
      r_hsync     <= w_hs ^ ~HS_POL;
      r_vsync     <= w_vs ^ ~VS_POL;
      r_rgb       <= w_active ? BLANK_RGB : '0;
      r_underflow <= 1'b0;
      r_sync_err  <= 1'b0;
      r_locked    <= (r_state == LOCKED);
      case (r_state)
        SEEK: if (w_sof) r_state <= WAIT;
        WAIT, LOCKED:
          if (w_slot) begin
            if (!s_axis_tvalid) begin
              r_underflow <= 1'b1;
              r_state     <= SEEK;
              r_locked    <= 1'b0;
            end else begin
              r_rgb      <= s_axis_tdata[23:0];
              r_sync_err <= w_err;
              r_state    <= w_err ? SEEK : LOCKED;
              r_locked   <= ~w_err;
            end
          end
        default: r_state <= SEEK;
      endcase
    end
endmodule

// File: tb/tb_axis_video_timing.sv
// tb_axis_video_timing: randomized stream stimulus against a slot-level reference model of the lock rules
module tb_axis_video_timing;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  logic clk = 1'b0, rst_n = 1'b0;
  logic tvalid = 1'b0, tready, tuser = 1'b0, tlast = 1'b0;
  logic [31:0] tdata = '0;
  logic [7:0] red, green, blue;
  logic hsync, vsync, de, locked, underflow, sync_err;
  always #5 clk = ~clk;
  axis_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .BLANK_RGB(24'h000000)
  ) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tdata(tdata), .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync), .de(de),
    .locked(locked), .underflow(underflow), .sync_err(sync_err)
  );
  typedef struct {logic [23:0] d; bit u; bit l; bit g;} beat_t;
  beat_t q[$];
  bit pres;
  int gap_pct;
  int slot;
  bit m_sync, m_held;
  logic [23:0] e_rgb;
  bit e_de, e_hs, e_vs, e_lk, e_uf, e_se;
  int n_chk, n_fail;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s slot=%0d got=%h exp=%h", tag, slot, got, exp);
    end
  endtask
  task automatic set_rst_exp();
    e_rgb = '0; e_de = 0; e_hs = 1; e_vs = 1; e_lk = 0; e_uf = 0; e_se = 0;
    slot = 0; m_sync = 0; m_held = 0;
  endtask
  task automatic chk_outs();
    chk("rgb", 32'({red, green, blue}), 32'(e_rgb));
    chk("de", 32'(de), 32'(e_de));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("locked", 32'(locked), 32'(e_lk));
    chk("underflow", 32'(underflow), 32'(e_uf));
    chk("sync_err", 32'(sync_err), 32'(e_se));
  endtask
  task automatic model(output bit rdy);
    int h, v;
    bit act, org, take;
    h = slot % HT;
    v = (slot / HT) % VT;
    org = (slot % FT) == 0;
    act = (h < HA) && (v < VA);
    take = act && (m_sync || (m_held && org));
    rdy = (!m_sync && !m_held) ? !(tvalid && tuser) : take;
    e_de = act;
    e_hs = !(h >= HA + HF && h < HA + HF + HS);
    e_vs = !(v >= VA + VF && v < VA + VF + VS);
    e_rgb = '0; e_uf = 0; e_se = 0;
    if (!m_sync && !m_held && tvalid && tuser) m_held = 1;
    else if (take) begin
      m_held = 0;
      if (!tvalid) begin
        e_uf = 1;
        m_sync = 0;
      end else begin
        e_rgb = tdata[23:0];
        e_se = (tuser != org) || (tlast != (h == HA - 1));
        m_sync = !e_se;
      end
    end
    e_lk = m_sync;
  endtask
  task automatic step();
    bit rdy;
    beat_t b;
    @(negedge clk);
    if (!pres && q.size() > 0) begin
      if (q[0].g) begin
        b = q.pop_front();
        b.g = 0;
        q.push_front(b);
      end else if ($urandom_range(99) >= gap_pct) pres = 1;
    end
    tvalid = pres;
    tdata = $urandom;
    tuser = 1'($urandom);
    tlast = 1'($urandom);
    if (pres) begin
      tdata[23:0] = q[0].d;
      tuser = q[0].u;
      tlast = q[0].l;
    end
    #1;
    if (rst_n) model(rdy);
    else begin
      rdy = 0;
      set_rst_exp();
    end
    chk("tready", 32'(tready), 32'(rdy));
    @(posedge clk);
    #1;
    chk_outs();
    if (rst_n) begin
      slot++;
      if (pres && rdy) begin
        void'(q.pop_front());
        pres = 0;
      end
    end
  endtask
  task automatic push_frame(input int bl, input int bp, input int gl, input int gp);
    beat_t b;
    for (int v = 0; v < VA; v++)
      for (int h = 0; h < HA; h++) begin
        b.d = 24'($urandom);
        b.u = (v == 0 && h == 0);
        b.l = (v == bl) ? (h == bp) : (h == HA - 1);
        b.g = (v == gl && h == gp);
        q.push_back(b);
      end
  endtask
  task automatic push_junk(input int n);
    beat_t b;
    repeat (n) begin
      b.d = 24'($urandom);
      b.u = 0;
      b.l = 1'($urandom);
      b.g = 0;
      q.push_back(b);
    end
  endtask
  task automatic run();
    int lim;
    lim = 4 * FT * (q.size() / (HA * VA) + 2);
    for (int i = 0; i < lim && (q.size() > 0 || pres); i++) step();
    chk("drain", 32'(q.size()), 32'(0));
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    gap_pct = 0;
    pres = 0;
    set_rst_exp();
    repeat (5) step();
    rst_n = 1'b1;
    push_junk(3);
    repeat (3) push_frame(-1, -1, -1, -1);
    run();
    push_frame(-1, -1, 1, 3);
    repeat (2) push_frame(-1, -1, -1, -1);
    run();
    push_frame(0, 5, -1, -1);
    repeat (2) push_frame(-1, -1, -1, -1);
    run();
    gap_pct = 2;
    repeat (8) begin
      int k;
      k = int'($urandom_range(3));
      if (k == 1) push_junk(int'($urandom_range(5, 1)));
      push_frame(k == 2 ? int'($urandom_range(VA - 1)) : -1, int'($urandom_range(HA - 2)),
                 k == 3 ? int'($urandom_range(VA - 1)) : -1, int'($urandom_range(HA - 1)));
    end
    run();
    gap_pct = 0;
    repeat (2) push_frame(-1, -1, -1, -1);
    for (int i = 0; i < 4 * FT && !(m_sync && slot % FT == 2 * HT + 4); i++) step();
    chk("mid_frame_reach", 32'(m_sync && slot % FT == 2 * HT + 4), 32'(1));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    pres = 0;
    tvalid = 1'b0;
    set_rst_exp();
    chk_outs();
    chk("tready_rst", 32'(tready), 32'(0));
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) push_frame(-1, -1, -1, -1);
    run();
    repeat (FT) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
